// File: rtl/l2_sched_pkg.sv
// rtl/l2_sched_pkg.sv - shared defaults, lower-side FSM states and port ids for the L2 scheduler
package l2_sched_pkg;

  localparam int DEPTH_DEF  = 4;
  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_RESP   = 2'd2,
    ST_WAITLO = 2'd3
  } lo_state_e;

  typedef enum logic {
    PORT_1 = 1'b0,
    PORT_2 = 1'b1
  } port_id_e;

endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - in-order request queue with DEPTH-modulo pointers and occupancy count
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      // simultaneous push and pop leaves occupancy unchanged
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/arbiter_l2_sched.sv
// rtl/arbiter_l2_sched.sv - two-port request arbiter feeding a 4-phase lower-level handshake
module arbiter_l2_sched
  import l2_sched_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic              rw_1,
  input  logic              ce_1,
  input  logic              pro_1,
  output logic              ACK_1,
  output logic              RDY_1,
  output logic [DATA_W-1:0] data_out_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic              rw_2,
  input  logic              ce_2,
  input  logic              pro_2,
  output logic              ACK_2,
  output logic              RDY_2,
  output logic [DATA_W-1:0] data_out_2,
  output logic [ADDR_W-1:0] addr_low,
  output logic [DATA_W-1:0] wdata_low,
  input  logic [DATA_W-1:0] rdata_low,
  output logic              rw_low,
  output logic              ce_low,
  input  logic              RDY_low,
  output logic              full
);

  localparam int ENT_W = 2 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  lo_state_e         state;
  port_id_e          rr_next;
  port_id_e          cur_id;
  logic              pick_2;
  logic              push;
  logic              pop;
  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [ENT_W-1:0]  push_data;
  logic [ENT_W-1:0]  head;
  logic              head_id;
  logic              head_rw;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  // priority hint decides a contested cycle; equal hints fall back to round-robin
  always_comb begin
    pick_2 = ce_2;
    if (ce_1 && ce_2) begin
      if (pro_1 != pro_2) pick_2 = pro_2;
      else                pick_2 = (rr_next == PORT_2);
    end
  end

  assign push      = (ce_1 | ce_2) & ~q_full & rst_n;
  assign ACK_1     = push & ~pick_2;
  assign ACK_2     = push & pick_2;
  assign push_data = pick_2 ? {PORT_2, rw_2, addr_2, data_in_2}
                            : {PORT_1, rw_1, addr_1, data_in_1};
  assign {head_id, head_rw, head_addr, head_data} = head;
  assign pop  = (state == ST_IDLE) & ~q_empty;
  assign full = (q_count == CNT_W'(DEPTH));

  req_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_next <= PORT_1;
    else if (push) rr_next <= pick_2 ? PORT_1 : PORT_2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_id     <= PORT_1;
      ce_low     <= 1'b0;
      rw_low     <= 1'b1;
      addr_low   <= '0;
      wdata_low  <= '0;
      RDY_1      <= 1'b0;
      RDY_2      <= 1'b0;
      data_out_1 <= '0;
      data_out_2 <= '0;
    end else begin
      RDY_1 <= 1'b0;
      RDY_2 <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            addr_low  <= head_addr;
            wdata_low <= head_data;
            rw_low    <= head_rw;
            cur_id    <= port_id_e'(head_id);
            ce_low    <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (RDY_low) begin
            ce_low <= 1'b0;
            if (cur_id == PORT_1) begin
              RDY_1 <= 1'b1;
              if (rw_low) data_out_1 <= rdata_low;
            end else begin
              RDY_2 <= 1'b1;
              if (rw_low) data_out_2 <= rdata_low;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_WAITLO;
        ST_WAITLO: begin
          if (!RDY_low) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_l2_sched.sv
// tb/tb_arbiter_l2_sched.sv - scoreboard bench with a transaction-level model of the scheduler
module tb_arbiter_l2_sched;

  localparam int DEPTH = 4;
  localparam int AW    = 24;
  localparam int DW    = 32;

  logic          clk, rst_n;
  logic [DW-1:0] data_in_1, data_in_2, data_out_1, data_out_2;
  logic [AW-1:0] addr_1, addr_2, addr_low;
  logic          rw_1, rw_2, ce_1, ce_2, pro_1, pro_2;
  logic          ACK_1, ACK_2, RDY_1, RDY_2;
  logic [DW-1:0] wdata_low, rdata_low;
  logic          rw_low, ce_low, RDY_low, full;

  arbiter_l2_sched #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in_1(data_in_1), .addr_1(addr_1), .rw_1(rw_1), .ce_1(ce_1), .pro_1(pro_1),
    .ACK_1(ACK_1), .RDY_1(RDY_1), .data_out_1(data_out_1),
    .data_in_2(data_in_2), .addr_2(addr_2), .rw_2(rw_2), .ce_2(ce_2), .pro_2(pro_2),
    .ACK_2(ACK_2), .RDY_2(RDY_2), .data_out_2(data_out_2),
    .addr_low(addr_low), .wdata_low(wdata_low), .rdata_low(rdata_low),
    .rw_low(rw_low), .ce_low(ce_low), .RDY_low(RDY_low), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    bit          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          exp_q[$];
  txn_t          fly_q[$];
  int            tests = 0, fails = 0;
  int            qcount = 0, last_g = 2;
  bit            granted1 = 0, granted2 = 0;
  logic [DW-1:0] dout_m1 = '0, dout_m2 = '0, exp_rdata = '0;
  bit            prev_ce_low = 0;
  int            cyc = 0, rise_cyc = 0;
  bit            hold = 0, use_forced = 0;
  int            fixed_dly = -1;
  logic [DW-1:0] forced_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: predicts grants/full from queue occupancy and checks the lower side.
  always @(negedge clk) begin
    txn_t t;
    int   g;
    if (!rst_n) begin
      prev_ce_low = 0;
    end else begin
      if (ce_low && !prev_ce_low) begin
        rise_cyc = cyc;
        qcount--;
        if (exp_q.size() == 0) chk("unexpected_ce_low", 1, 0);
        else begin
          t = exp_q.pop_front();
          chk("addr_low", addr_low, t.addr);
          chk("rw_low", rw_low, t.rw);
          if (!t.rw) chk("wdata_low", wdata_low, t.data);
          fly_q.push_back(t);
        end
      end
      prev_ce_low = ce_low;

      if (RDY_1 || RDY_2) begin
        chk("RDY_both", RDY_1 & RDY_2, 0);
        chk("ce_low_in_RESP", ce_low, 0);
        if (fly_q.size() == 0) chk("unexpected_RDY", 1, 0);
        else begin
          t = fly_q.pop_front();
          chk("RDY_port", RDY_2 ? 2 : 1, t.port);
          if (t.rw) begin
            if (t.port == 1) dout_m1 = exp_rdata;
            else             dout_m2 = exp_rdata;
          end
          chk("data_out_1", data_out_1, dout_m1);
          chk("data_out_2", data_out_2, dout_m2);
        end
      end

      chk("full", full, qcount == DEPTH);
      g = 0;
      if (qcount < DEPTH) begin
        if (ce_1 && ce_2) begin
          if (pro_1 != pro_2) g = pro_1 ? 1 : 2;
          else                g = (last_g == 1) ? 2 : 1;
        end else if (ce_1) g = 1;
        else if (ce_2) g = 2;
      end
      chk("ACK_1", ACK_1, g == 1);
      chk("ACK_2", ACK_2, g == 2);
      if (g != 0) begin
        last_g = g;
        qcount++;
        if (g == 1) begin
          t = '{1, rw_1, addr_1, data_in_1};
          granted1 = 1;
        end else begin
          t = '{2, rw_2, addr_2, data_in_2};
          granted2 = 1;
        end
        exp_q.push_back(t);
      end
    end
  end

  // Lower-level responder: 4-phase handshake with configurable delay and stall.
  initial begin
    int rs, cnt, wait_n;
    RDY_low = 0; rdata_low = '0; rs = 0; cnt = 0; wait_n = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        rs = 0; RDY_low = 0;
      end else begin
        case (rs)
          0: if (ce_low && !hold) begin
               wait_n = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
               cnt = 0; rs = 1;
             end
          1: if (!ce_low) rs = 0;
             else if (cnt >= wait_n) begin
               rdata_low = use_forced ? forced_rdata : $urandom;
               exp_rdata = rdata_low;
               RDY_low = 1; cnt = 0; rs = 2;
             end else cnt++;
          2: if (!ce_low) begin
               cnt = 0; wait_n = $urandom_range(0, 2); rs = 3;
             end else if (++cnt > 50) begin
               chk("ce_low_drop_timeout", 1, 0);
               RDY_low = 0; rs = 0;
             end
          default: if (cnt >= wait_n) begin
               RDY_low = 0; rs = 0;
             end else cnt++;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (granted1) begin ce_1 = 0; granted1 = 0; end
    if (granted2) begin ce_2 = 0; granted2 = 0; end
  endtask

  task automatic issue(input int p, input bit rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit pro);
    if (p == 1) begin ce_1 = 1; rw_1 = rw; addr_1 = a; data_in_1 = d; pro_1 = pro; end
    else        begin ce_2 = 1; rw_2 = rw; addr_2 = a; data_in_2 = d; pro_2 = pro; end
  endtask

  task automatic wait_ports(input int bound);
    int n = 0;
    while ((ce_1 || ce_2) && n < bound) begin step(); n++; end
    if (ce_1 || ce_2) chk("ack_timeout", 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    wait_ports(200);
    while ((exp_q.size() != 0 || fly_q.size() != 0 || RDY_low || ce_low) && n < 500) begin
      step(); n++;
    end
    chk("drain_timeout", n >= 500, 0);
  endtask

  initial begin
    int c0;
    rst_n = 0;
    ce_1 = 0; ce_2 = 0; rw_1 = 0; rw_2 = 0; pro_1 = 0; pro_2 = 0;
    addr_1 = '0; addr_2 = '0; data_in_1 = '0; data_in_2 = '0;
    repeat (3) step();
    chk("rst_ce_low", ce_low, 0);
    chk("rst_rw_low", rw_low, 1);
    chk("rst_addr_low", addr_low, 0);
    chk("rst_wdata_low", wdata_low, 0);
    chk("rst_full", full, 0);
    chk("rst_dout1", data_out_1, 0);
    chk("rst_dout2", data_out_2, 0);
    rst_n = 1;
    step();

    // single read with fixed lower latency
    fixed_dly = 2; use_forced = 1; forced_rdata = 32'hDEADBEEF;
    issue(1, 1, 24'h000010, '0, 0);
    c0 = cyc;
    drain();
    chk("min_latency", rise_cyc - c0, 2);
    chk("read_deadbeef", data_out_1, 32'hDEADBEEF);
    use_forced = 0; fixed_dly = -1;

    // priority hint beats round-robin
    issue(1, 1, 24'h000100, '0, 0);
    issue(2, 1, 24'h000200, '0, 1);
    drain();

    // equal priority, repeated contention
    for (int i = 0; i < 4; i++) begin
      issue(1, 0, 24'(24'h300 + i), $urandom, 0);
      issue(2, 0, 24'(24'h400 + i), $urandom, 0);
      wait_ports(50);
    end
    drain();

    // fill the queue with the lower side stalled
    hold = 1;
    for (int i = 0; i < 5; i++) begin
      issue(1, 1, 24'(24'h500 + i), '0, 0);
      wait_ports(20);
    end
    chk("full_when_stalled", full, 1);
    issue(1, 1, 24'h000505, '0, 0);
    repeat (5) step();
    chk("sixth_blocked_full", full, 1);
    hold = 0;
    drain();

    // write leaves read data untouched
    issue(2, 0, 24'hABCDEF, 32'h12345678, 0);
    drain();

    // reset mid-transaction with requests queued
    hold = 1;
    for (int i = 0; i < 4; i++) begin
      issue(1, 1, 24'(24'h600 + i), '0, 0);
      wait_ports(20);
    end
    begin
      int n = 0;
      while (!(qcount == 3 && ce_low) && n < 20) begin step(); n++; end
      chk("reset_setup", qcount == 3 && ce_low, 1);
    end
    #2 rst_n = 0;
    #1;
    chk("async_rst_ce_low", ce_low, 0);
    chk("async_rst_full", full, 0);
    chk("async_rst_rw_low", rw_low, 1);
    chk("async_rst_dout1", data_out_1, 0);
    exp_q.delete(); fly_q.delete();
    qcount = 0; last_g = 2; dout_m1 = '0; dout_m2 = '0;
    ce_1 = 0; ce_2 = 0; granted1 = 0; granted2 = 0; hold = 0;
    repeat (2) step();
    rst_n = 1;
    repeat (10) step();
    chk("post_rst_idle", ce_low, 0);
    chk("post_rst_full", full, 0);

    // randomized traffic against the scoreboard
    for (int i = 0; i < 600; i++) begin
      step();
      if (!ce_1 && ($urandom % 3 == 0)) issue(1, 1'($urandom), 24'($urandom), $urandom, 1'($urandom));
      if (!ce_2 && ($urandom % 3 == 0)) issue(2, 1'($urandom), 24'($urandom), $urandom, 1'($urandom));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
